// File: rtl/fd_pipe_stage_if.sv
// Valid/ready bus carrying a PC and an instruction between pipeline stages.
// The master drives valid/pc/instr and the slave answers with ready.
interface fd_pipe_stage_if #(
   parameter int unsigned PC_W    = 32,
   parameter int unsigned INSTR_W = 32
);
   logic               valid;
   logic               ready;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] instr;

   modport master (
      output valid,
      output pc,
      output instr,
      input  ready
   );

   modport slave (
      input  valid,
      input  pc,
      input  instr,
      output ready
   );
endinterface

// File: rtl/fd_pipe_stage.sv
// Fetch->decode pipeline register with a 2-entry skid buffer.
// The head (main) register drives decode; the skid register absorbs one
// extra fetch beat so that in_ready can come straight from registered state
// and never depends on out_ready in the same cycle.
module fd_pipe_stage #(
   parameter int unsigned        PC_W      = 32,
   parameter int unsigned        INSTR_W   = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
   parameter int unsigned        STALL_W   = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               flush,
   fd_pipe_stage_if.slave     fetch_if,
   fd_pipe_stage_if.master    decode_if,
   output logic [STALL_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   localparam logic [STALL_W-1:0] STALL_MAX = '1;
   localparam logic [STALL_W-1:0] STALL_ONE = 1;

   state_t             state_q,      state_d;
   logic [PC_W-1:0]    main_pc_q,    main_pc_d;
   logic [INSTR_W-1:0] main_instr_q, main_instr_d;
   logic [PC_W-1:0]    skid_pc_q,    skid_pc_d;
   logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
   logic [STALL_W-1:0] stall_q,      stall_d;

   logic in_ready;
   logic out_valid;
   logic ifire;
   logic ofire;

   // Handshake terms: in_ready comes from state only, gated by reset.
   assign in_ready  = reset_n & (state_q != TWO);
   assign out_valid = (state_q != EMPTY);
   assign ifire     = fetch_if.valid & in_ready;
   assign ofire     = out_valid & decode_if.ready;

   assign fetch_if.ready  = in_ready;
   assign decode_if.valid = out_valid;
   assign decode_if.pc    = main_pc_q;
   assign decode_if.instr = out_valid ? main_instr_q : NOP_INSTR;
   assign stall_count     = stall_q;

   // Next-state, entry moves and stall counting.
   always_comb begin
      state_d      = state_q;
      main_pc_d    = main_pc_q;
      main_instr_d = main_instr_q;
      skid_pc_d    = skid_pc_q;
      skid_instr_d = skid_instr_q;
      stall_d      = stall_q;

      if (flush) begin
         // Redirect: drop both entries and whatever fetch offers this cycle.
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (ifire) begin
                  main_pc_d    = fetch_if.pc;
                  main_instr_d = fetch_if.instr;
                  state_d      = ONE;
               end
            end
            ONE: begin
               if (ifire && ofire) begin
                  main_pc_d    = fetch_if.pc;
                  main_instr_d = fetch_if.instr;
               end else if (ifire) begin
                  skid_pc_d    = fetch_if.pc;
                  skid_instr_d = fetch_if.instr;
                  state_d      = TWO;
               end else if (ofire) begin
                  state_d      = EMPTY;
               end
            end
            TWO: begin
               if (ofire) begin
                  main_pc_d    = skid_pc_q;
                  main_instr_d = skid_instr_q;
                  state_d      = ONE;
               end
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end

      // Count backpressured cycles; a flushed cycle is not a stall.
      if (out_valid && !decode_if.ready && !flush && (stall_q != STALL_MAX)) begin
         stall_d = stall_q + STALL_ONE;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q      <= EMPTY;
         main_pc_q    <= '0;
         main_instr_q <= NOP_INSTR;
         skid_pc_q    <= '0;
         skid_instr_q <= '0;
         stall_q      <= '0;
      end else begin
         state_q      <= state_d;
         main_pc_q    <= main_pc_d;
         main_instr_q <= main_instr_d;
         skid_pc_q    <= skid_pc_d;
         skid_instr_q <= skid_instr_d;
         stall_q      <= stall_d;
      end
   end

endmodule

// File: tb/tb_fd_pipe_stage.sv
// Directed, table-driven bench for fd_pipe_stage.
module tb_fd_pipe_stage;

   localparam int unsigned        PC_W    = 32;
   localparam int unsigned        INSTR_W = 32;
   localparam int unsigned        STALL_W = 3;
   localparam logic [INSTR_W-1:0] NOP     = 32'h0000_0013;

   logic               clock;
   logic               reset_n;
   logic               flush;
   logic [STALL_W-1:0] stall_count;

   fd_pipe_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) in_bus ();
   fd_pipe_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) out_bus ();

   fd_pipe_stage #(
      .PC_W     (PC_W),
      .INSTR_W  (INSTR_W),
      .NOP_INSTR(NOP),
      .STALL_W  (STALL_W)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .flush      (flush),
      .fetch_if   (in_bus),
      .decode_if  (out_bus),
      .stall_count(stall_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rst_n;
      logic        iv;
      logic [31:0] ipc;
      logic [31:0] iin;
      logic        fl;
      logic        ordy;
      logic        e_rdy;
      logic        e_ov;
      logic [31:0] e_pc;
      logic [31:0] e_in;
      logic [2:0]  e_st;
   } vec_t;

   vec_t vecs[$];
   int   nvec = 0;
   int   nerr = 0;

   task automatic add(input logic rst_n, input logic iv, input logic [31:0] ipc,
                      input logic [31:0] iin, input logic fl, input logic ordy,
                      input logic e_rdy, input logic e_ov, input logic [31:0] e_pc,
                      input logic [31:0] e_in, input logic [2:0] e_st);
      vec_t v;
      v.rst_n = rst_n; v.iv = iv; v.ipc = ipc; v.iin = iin; v.fl = fl; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_pc = e_pc; v.e_in = e_in; v.e_st = e_st;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s step %0d: got %h, want %h", name, idx, act, exp);
      end
   endtask

   // Drive one vector, clock it in, then compare outputs 1 ns after the edge.
   task automatic apply(input vec_t v, input int idx);
      reset_n      = v.rst_n;
      in_bus.valid = v.iv;
      in_bus.pc    = v.ipc;
      in_bus.instr = v.iin;
      flush        = v.fl;
      out_bus.ready = v.ordy;
      @(posedge clock);
      #1;
      nvec++;
      check("in_ready",    idx, {31'd0, in_bus.ready},  {31'd0, v.e_rdy});
      check("out_valid",   idx, {31'd0, out_bus.valid}, {31'd0, v.e_ov});
      check("out_pc",      idx, out_bus.pc,             v.e_pc);
      check("out_instr",   idx, out_bus.instr,          v.e_in);
      check("stall_count", idx, {29'd0, stall_count},   {29'd0, v.e_st});
   endtask

   initial begin
      vec_t v;
      int   st;
      reset_n       = 1'b0;
      flush         = 1'b0;
      in_bus.valid  = 1'b0;
      in_bus.pc     = '0;
      in_bus.instr  = '0;
      out_bus.ready = 1'b0;

      //   rst iv  ipc        iin       fl  ordy  rdy ov  pc         instr     st
      // reset held with in_valid=1
      add(0, 1, 32'h50,  32'h55, 0, 0,   0, 0, 32'h0,   NOP,      3'd0);
      add(0, 1, 32'h50,  32'h55, 0, 0,   0, 0, 32'h0,   NOP,      3'd0);
      add(0, 1, 32'h50,  32'h55, 0, 0,   0, 0, 32'h0,   NOP,      3'd0);
      // streaming back-to-back
      add(1, 1, 32'h0,   32'hA,  0, 1,   1, 1, 32'h0,   32'hA,    3'd0);
      add(1, 1, 32'h4,   32'hB,  0, 1,   1, 1, 32'h4,   32'hB,    3'd0);
      add(1, 1, 32'h8,   32'hC,  0, 1,   1, 1, 32'h8,   32'hC,    3'd0);
      add(1, 0, 32'h0,   32'h0,  0, 1,   1, 0, 32'h8,   NOP,      3'd0);
      // backpressure into the skid register
      add(1, 1, 32'h0,   32'h10, 0, 0,   1, 1, 32'h0,   32'h10,   3'd0);
      add(1, 1, 32'h4,   32'h14, 0, 0,   0, 1, 32'h0,   32'h10,   3'd1);
      add(1, 1, 32'h8,   32'h18, 0, 0,   0, 1, 32'h0,   32'h10,   3'd2);
      add(1, 1, 32'h8,   32'h18, 0, 0,   0, 1, 32'h0,   32'h10,   3'd3);
      add(1, 1, 32'h8,   32'h18, 0, 1,   1, 1, 32'h4,   32'h14,   3'd3);
      add(1, 1, 32'h8,   32'h18, 0, 1,   1, 1, 32'h8,   32'h18,   3'd3);
      add(1, 0, 32'h0,   32'h0,  0, 1,   1, 0, 32'h8,   NOP,      3'd3);
      // flush while holding two entries
      add(1, 1, 32'h0,   32'h20, 0, 0,   1, 1, 32'h0,   32'h20,   3'd3);
      add(1, 1, 32'h4,   32'h24, 0, 0,   0, 1, 32'h0,   32'h20,   3'd4);
      add(1, 1, 32'h8,   32'h28, 1, 0,   1, 0, 32'h0,   NOP,      3'd4);
      add(1, 1, 32'h100, 32'h30, 0, 1,   1, 1, 32'h100, 32'h30,   3'd4);
      add(1, 0, 32'h0,   32'h0,  0, 1,   1, 0, 32'h100, NOP,      3'd4);
      // flush in ONE drops an input that fires the same cycle
      add(1, 1, 32'h200, 32'h40, 0, 0,   1, 1, 32'h200, 32'h40,   3'd4);
      add(1, 1, 32'h204, 32'h44, 1, 1,   1, 0, 32'h200, NOP,      3'd4);
      add(1, 0, 32'h0,   32'h0,  0, 1,   1, 0, 32'h200, NOP,      3'd4);

      for (int i = 0; i < vecs.size(); i++) begin
         apply(vecs[i], i);
      end

      // Saturation: load one entry, then hold out_ready low for 10 cycles.
      v = '{1, 1, 32'h300, 32'h50, 0, 0, 1, 1, 32'h300, 32'h50, 3'd4};
      apply(v, 100);
      st = 4;
      for (int k = 1; k <= 10; k++) begin
         st = (st < 7) ? st + 1 : 7;
         v = '{1, 0, 32'h0, 32'h0, 0, 0, 1, 1, 32'h300, 32'h50, st[2:0]};
         apply(v, 100 + k);
      end

      // Reset in the middle of the stall returns everything to reset values.
      v = '{0, 1, 32'h400, 32'h60, 0, 0, 0, 0, 32'h0, NOP, 3'd0};
      apply(v, 200);
      v = '{1, 0, 32'h0, 32'h0, 0, 0, 1, 0, 32'h0, NOP, 3'd0};
      apply(v, 201);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
